// File: rtl/sd_init_ctrl.sv
// rtl/sd_init_ctrl.sv - SPI-mode SD card initialisation sequencer (CMD0..CMD59).
// Optional macro SD_OCR_READ_EN adds the CMD58 OCR read and drives HC from OCR bit 30.
module sd_init_ctrl #(
  parameter int DIV_INIT     = 100,
  parameter int DIV_FAST     = 2,
  parameter int POWERUP_CLKS = 80,
  parameter int RESP_TIMEOUT = 64,
  parameter int CMD_RETRIES  = 4,
  parameter int ACMD41_POLLS = 1024
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       DO,
  output logic       SCLK,
  output logic       DI,
  output logic       CS,
  output logic       OK,
  output logic       ERR,
  output logic [2:0] ERR_CODE,
  output logic       HC
);

  typedef enum logic [2:0] {IDLE, POWERUP, SEND, WAIT_RESP, RECV, GAP, DONE, FAIL} state_t;

  localparam logic [2:0] STEP_CMD0   = 3'd1;
  localparam logic [2:0] STEP_CMD8   = 3'd2;
  localparam logic [2:0] STEP_CMD55  = 3'd3;
  localparam logic [2:0] STEP_ACMD41 = 3'd4;
  localparam logic [2:0] STEP_CMD58  = 3'd5;
  localparam logic [2:0] STEP_CMD59  = 3'd6;

  localparam logic [15:0] DIV_INIT_LAST = 16'(DIV_INIT - 1);
  localparam logic [15:0] DIV_FAST_LAST = 16'(DIV_FAST - 1);
  localparam logic [15:0] PU_LAST       = 16'(POWERUP_CLKS - 1);
  localparam logic [15:0] TMO_LAST      = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0] POLL_LAST     = 16'(ACMD41_POLLS - 1);
  localparam logic [7:0]  RETRY_LAST    = 8'(CMD_RETRIES - 1);

  state_t      state, state_n;
  logic [2:0]  step, step_n, next_step, err_code, err_code_n;
  logic [15:0] cnt, cnt_n, poll, poll_n, div_cnt, div_last, rx_last;
  logic [7:0]  retry, retry_n, r1;
  logic [47:0] shift, shift_n;
  logic [39:0] rx, rx_n;
  logic        tmo, tmo_n, do_s, sclk_q;
  logic        running, tick, rise, fall, resp_long, resp_good, resp_busy;

  function automatic logic [47:0] frame_of(input logic [2:0] s);
    case (s)
      STEP_CMD0:   return 48'h40_0000_0000_95;
      STEP_CMD8:   return 48'h48_0000_01AA_87;
      STEP_CMD55:  return 48'h77_0000_0000_65;
      STEP_ACMD41: return 48'h69_4000_0000_77;
      STEP_CMD58:  return 48'h7A_0000_0000_FD;
      STEP_CMD59:  return 48'h7B_0000_0000_91;
      default:     return 48'hFFFF_FFFF_FFFF;
    endcase
  endfunction

  // Every protocol action happens on an SCLK edge event derived from the divider.
  assign running  = (state != IDLE) && (state != FAIL);
  assign div_last = (state == DONE) ? DIV_FAST_LAST : DIV_INIT_LAST;
  assign tick     = running && (div_cnt >= div_last);
  assign rise     = tick && !sclk_q;
  assign fall     = tick && sclk_q;

  assign resp_long = (step == STEP_CMD8) || (step == STEP_CMD58);
  assign rx_last   = resp_long ? 16'd39 : 16'd7;
  assign r1        = resp_long ? rx[39:32] : rx[7:0];

  always_comb begin
    resp_good = 1'b0;
    resp_busy = 1'b0;
    next_step = step;
    case (step)
      STEP_CMD0: begin
        resp_good = (r1 == 8'h01);
        next_step = STEP_CMD8;
      end
      STEP_CMD8: begin
        resp_good = (r1 == 8'h01) && (rx[11:8] == 4'h1) && (rx[7:0] == 8'hAA);
        next_step = STEP_CMD55;
      end
      STEP_CMD55: begin
        resp_good = (r1 == 8'h00) || (r1 == 8'h01);
        next_step = STEP_ACMD41;
      end
      STEP_ACMD41: begin
        resp_good = (r1 == 8'h00);
        resp_busy = (r1 == 8'h01);
`ifdef SD_OCR_READ_EN
        next_step = STEP_CMD58;
`else
        next_step = STEP_CMD59;
`endif
      end
      STEP_CMD58: begin
        resp_good = (r1 == 8'h00);
        next_step = STEP_CMD59;
      end
      STEP_CMD59: resp_good = (r1 == 8'h00);
      default: ;
    endcase
    if (tmo) begin
      resp_good = 1'b0;
      resp_busy = 1'b0;
    end
  end

  always_comb begin
    state_n    = state;
    step_n     = step;
    cnt_n      = cnt;
    retry_n    = retry;
    poll_n     = poll;
    shift_n    = shift;
    rx_n       = rx;
    tmo_n      = tmo;
    err_code_n = err_code;
    case (state)
      IDLE: if (START) begin
        state_n = POWERUP;
        cnt_n   = '0;
      end
      POWERUP: if (fall) begin
        if (cnt == PU_LAST) begin
          state_n = SEND;
          step_n  = STEP_CMD0;
          shift_n = frame_of(STEP_CMD0);
          cnt_n   = '0;
        end else cnt_n = cnt + 16'd1;
      end
      SEND: if (fall) begin
        if (cnt == 16'd47) begin
          state_n = WAIT_RESP;
          cnt_n   = '0;
        end else begin
          shift_n = {shift[46:0], 1'b1};
          cnt_n   = cnt + 16'd1;
        end
      end
      WAIT_RESP: if (fall) begin
        if (!do_s) begin
          state_n = RECV;
          rx_n    = {rx[38:0], 1'b0};
          cnt_n   = 16'd1;
        end else if (cnt == TMO_LAST) begin
          state_n = GAP;
          tmo_n   = 1'b1;
          cnt_n   = '0;
        end else cnt_n = cnt + 16'd1;
      end
      RECV: if (fall) begin
        rx_n = {rx[38:0], do_s};
        if (cnt == rx_last) begin
          state_n = GAP;
          cnt_n   = '0;
        end else cnt_n = cnt + 16'd1;
      end
      GAP: if (fall) begin
        if (cnt != 16'd7) cnt_n = cnt + 16'd1;
        else begin
          cnt_n   = '0;
          tmo_n   = 1'b0;
          state_n = SEND;
          if (resp_good) begin
            retry_n = '0;
            if (step == STEP_ACMD41) poll_n = '0;
            if (step == STEP_CMD59) state_n = DONE;
            else begin
              step_n  = next_step;
              shift_n = frame_of(next_step);
            end
          end else if (resp_busy) begin
            // Busy card: repoll from CMD55; only the poll budget accumulates.
            retry_n = '0;
            if (poll == POLL_LAST) begin
              state_n    = FAIL;
              err_code_n = STEP_ACMD41;
            end else begin
              poll_n  = poll + 16'd1;
              step_n  = STEP_CMD55;
              shift_n = frame_of(STEP_CMD55);
            end
          end else if (retry == RETRY_LAST) begin
            state_n    = FAIL;
            err_code_n = step;
          end else begin
            retry_n = retry + 8'd1;
            shift_n = frame_of(step);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      step     <= '0;
      cnt      <= '0;
      retry    <= '0;
      poll     <= '0;
      shift    <= '1;
      rx       <= '0;
      tmo      <= 1'b0;
      err_code <= '0;
      do_s     <= 1'b1;
      div_cnt  <= '0;
      sclk_q   <= 1'b0;
    end else begin
      state    <= state_n;
      step     <= step_n;
      cnt      <= cnt_n;
      retry    <= retry_n;
      poll     <= poll_n;
      shift    <= shift_n;
      rx       <= rx_n;
      tmo      <= tmo_n;
      err_code <= err_code_n;
      if (rise) do_s <= DO;
      if (!running) begin
        div_cnt <= '0;
        sclk_q  <= 1'b0;
      end else if (tick) begin
        div_cnt <= '0;
        sclk_q  <= ~sclk_q;
      end else div_cnt <= div_cnt + 16'd1;
    end
  end

`ifdef SD_OCR_READ_EN
  logic hc_q;
  always_ff @(posedge CLK) begin
    if (RST) hc_q <= 1'b0;
    else if (state == GAP && fall && cnt == 16'd7 && step == STEP_CMD58 && resp_good)
      hc_q <= rx[30];
  end
  assign HC = hc_q;
`else
  assign HC = 1'b0;
`endif

  assign SCLK     = sclk_q;
  assign CS       = !((state == SEND) || (state == WAIT_RESP) || (state == RECV));
  assign DI       = (state == SEND) ? shift[47] : 1'b1;
  assign OK       = (state == DONE);
  assign ERR      = (state == FAIL);
  assign ERR_CODE = err_code;

endmodule
